// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a valid/ready request port.
// A request is accepted in IDLE, waits WAIT_CYCLES states in WAIT, then emits a
// one-cycle registered response in RESP. Loads and stores take effect on the
// edge that enters RESP (the commit edge).
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject byte addresses whose
// low two bits are non-zero; without it those bits are simply ignored.
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;

    // Request captured at the IDLE handshake; WAIT/RESP never look at the ports
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;

    logic [31:0] rdata_reg;
    logic        err_reg;

    logic [31:0] mem [DEPTH];

    logic              accept;
    logic              commit;
    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [31:0]       cur_wdata;
    logic [ADDR_W-1:0] cur_idx;
    logic              range_err;
    logic              align_err;
    logic              cur_err;

    // With zero wait states the commit edge is the acceptance edge, so the
    // request is taken straight from the ports; otherwise from the latches.
    always_comb begin
        cur_we    = we_reg;
        cur_addr  = addr_reg;
        cur_wdata = wdata_reg;
        if (state_reg == ST_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end
        cur_idx   = cur_addr[ADDR_W+1:2];
        range_err = (cur_addr >> (ADDR_W + 2)) != 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
        align_err = cur_addr[1:0] != 2'b00;
`else
        align_err = 1'b0;
`endif
        cur_err   = range_err | align_err;
    end

    // Next-state, wait counter and handshake outputs
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept   = 1'b1;
                    cnt_next = WAIT_INIT;
                    if (WAIT_INIT != 4'd0) begin
                        state_next = ST_WAIT;
                    end else begin
                        state_next = ST_RESP;
                        commit     = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = ST_RESP;
                    commit     = 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register and wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Capture the request at the handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_reg    <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
        end else if (accept) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
        end
    end

    // Response data/flag, updated only at the commit edge and held otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else if (commit) begin
            err_reg <= cur_err;
            if (cur_err || cur_we) begin
                rdata_reg <= 32'd0;
            end else begin
                rdata_reg <= mem[cur_idx];
            end
        end
    end

    // Storage write; the rst term keeps a store from landing while reset is held
    always_ff @(posedge clk) begin
        if (rst && commit && cur_we && !cur_err) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances with 0, 1, 3 and 15 wait states,
// driven by directed steps and random traffic, checked against a word-array
// model of the memory and the fixed latency rule.
module tb_dmem_responder;

    localparam int NDUT = 4;

    function automatic int wait_of(input int d);
        case (d)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    logic              clk = 1'b0;
    logic [NDUT-1:0]   rst;
    logic [NDUT-1:0]   req_valid;
    logic [NDUT-1:0]   req_ready;
    logic [NDUT-1:0]   req_we;
    logic [31:0]       req_addr  [NDUT];
    logic [31:0]       req_wdata [NDUT];
    logic [NDUT-1:0]   rsp_valid;
    logic [31:0]       rsp_rdata [NDUT];
    logic [NDUT-1:0]   rsp_err;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        dmem_responder #(
            .ADDR_W      (8),
            .WAIT_CYCLES (wait_of(gi))
        ) u_dut (
            .clk       (clk),
            .rst       (rst[gi]),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_we    (req_we[gi]),
            .req_addr  (req_addr[gi]),
            .req_wdata (req_wdata[gi]),
            .rsp_valid (rsp_valid[gi]),
            .rsp_rdata (rsp_rdata[gi]),
            .rsp_err   (rsp_err[gi])
        );
    end

    int n_checks = 0;
    int n_fails  = 0;

    // Reference memory: 1 KiB byte space per instance, one entry per word
    logic [31:0] mdl_mem   [NDUT][256];
    bit          mdl_known [NDUT][256];

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
        end
    endtask

    // Expected outcome of one access from the address rules
    task automatic model_txn(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] exp_rdata, output bit exp_err);
        int idx;
        bit bad;
        bad = (addr >= 32'h400);
`ifdef DMEM_ALIGN_CHECK_EN
        if ((addr % 4) != 0) bad = 1'b1;
`endif
        idx       = int'((addr % 1024) / 4);
        exp_err   = bad;
        exp_rdata = 32'd0;
        if (!bad) begin
            if (we) begin
                mdl_mem[d][idx]   = wdata;
                mdl_known[d][idx] = 1'b1;
            end else begin
                exp_rdata = mdl_known[d][idx] ? mdl_mem[d][idx] : 32'hxxxxxxxx;
            end
        end
    endtask

    // One complete request/response with latency and handshake checks
    task automatic do_txn(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          t;
        int          n;
        t = 0;
        @(negedge clk);
        while (req_ready[d] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_req", d, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        model_txn(d, we, addr, wdata, exp_rdata, exp_err);
        @(posedge clk);
        #1;
        // Scramble inputs after the handshake; they must have no effect
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        n = 1;
        while (rsp_valid[d] !== 1'b1 && n < 40) begin
            chk("ready_low_in_wait", d, 32'(req_ready[d]), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", d, 32'(n), 32'(wait_of(d) + 1));
        chk("ready_low_in_resp", d, 32'(req_ready[d]), 32'd0);
        chk("rsp_rdata", d, rsp_rdata[d], exp_rdata);
        chk("rsp_err", d, 32'(rsp_err[d]), 32'(exp_err));
        $display("txn dut%0d we=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 d, we, addr, wdata, rsp_rdata[d], rsp_err[d], n);
        @(posedge clk);
        #1;
        chk("rsp_valid_one_cycle", d, 32'(rsp_valid[d]), 32'd0);
        chk("ready_after_resp", d, 32'(req_ready[d]), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag, input int d);
        chk({tag, "_ready"}, d, 32'(req_ready[d]), 32'd1);
        chk({tag, "_valid"}, d, 32'(rsp_valid[d]), 32'd0);
        chk({tag, "_rdata"}, d, rsp_rdata[d], 32'd0);
        chk({tag, "_err"},   d, 32'(rsp_err[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] exp_b2b;
        bit          we;
        int          r;
        int          idx;
        int          nresp;
        int          t;

        rst       = '0;
        req_valid = '0;
        req_we    = '0;
        for (int d = 0; d < NDUT; d++) begin
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
            for (int k = 0; k < 256; k++) mdl_known[d][k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) chk_reset_outputs("reset", d);
        @(negedge clk);
        rst = '1;

        // Store then load on the one-wait-state instance
        do_txn(1, 1'b1, 32'h10, 32'hDEADBEEF);
        do_txn(1, 1'b0, 32'h10, 32'h0);
        // Out-of-range store must not disturb word 0
        do_txn(1, 1'b1, 32'h0, 32'h0BADF00D);
        do_txn(1, 1'b1, 32'h400, 32'h12345678);
        do_txn(1, 1'b0, 32'h0, 32'h0);
        do_txn(1, 1'b0, 32'h80000004, 32'h0);
        // Misaligned load: rejected with the alignment check, mem[4] without
        do_txn(1, 1'b1, 32'h10, 32'h44444444);
        do_txn(1, 1'b0, 32'h12, 32'h0);

        // Back-to-back loads with req_valid held, zero wait states
        do_txn(0, 1'b1, 32'h24, 32'h5A5A1234);
        exp_b2b = mdl_mem[0][9];
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h24;
        nresp = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("b2b_ready", 0, 32'(req_ready[0]), 32'(i % 2));
            chk("b2b_valid", 0, 32'(rsp_valid[0]), 32'((i + 1) % 2));
            if (rsp_valid[0] === 1'b1) begin
                nresp++;
                chk("b2b_rdata", 0, rsp_rdata[0], exp_b2b);
                $display("txn dut0 b2b load addr=00000024 rdata=%h cycle=%0d", rsp_rdata[0], i);
            end
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("b2b_count", 0, 32'(nresp), 32'd5);

        // Reset in the middle of a store's wait states
        do_txn(2, 1'b1, 32'h20, 32'h1);
        do_txn(2, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        t = 0;
        while (req_ready[2] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h20;
        req_wdata[2] = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(posedge clk);
        #2;
        rst[2] = 1'b0;
        #1;
        chk_reset_outputs("midreset", 2);
        @(negedge clk);
        rst[2] = 1'b1;
        $display("txn dut2 store addr=00000020 wdata=cafef00d aborted by reset");
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("no_rsp_after_reset", 2, 32'(rsp_valid[2]), 32'd0);
        end
        do_txn(2, 1'b0, 32'h20, 32'h0);

        // Maximum wait states
        do_txn(3, 1'b1, 32'h3FC, 32'h87654321);
        do_txn(3, 1'b0, 32'h3FC, 32'h0);

        // Random traffic on every instance
        for (int d = 0; d < NDUT; d++) begin
            for (int k = 0; k < 20; k++) begin
                r   = int'($urandom_range(0, 9));
                idx = int'($urandom_range(0, 15));
                we  = 1'($urandom);
                w   = $urandom;
                if (r < 6)       a = 32'(idx * 4);
                else if (r == 6) a = 32'(idx * 4) + 32'($urandom_range(1, 3));
                else if (r == 7) a = 32'h400 + 32'($urandom_range(0, 1023));
                else             a = $urandom | 32'h80000000;
                // Avoid loading words that were never written
                if (!we && a < 32'h400 && !mdl_known[d][int'((a % 1024) / 4)]) we = 1'b1;
                do_txn(d, we, a, w);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
